// File: rtl/plic_gateway.sv
// Per-source PLIC gateway: turns a raw device interrupt into a pending bit and
// runs the claim/complete handshake, with deferred-edge counting in edge mode.
module plic_gateway #(
    parameter logic [3:0] ID          = 4'd1,
    parameter int         EDGE_CNT_W  = 3,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  irq_i,
    input  logic                  edge_mode_i,
    input  logic                  claim_i,
    input  logic [3:0]            claim_id_i,
    input  logic                  complete_i,
    input  logic [3:0]            complete_id_i,
    output logic                  ip_o,
    output logic                  busy_o,
    output logic [EDGE_CNT_W-1:0] pend_cnt_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_CLAIMED = 2'd2;

    localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   irq_s;
    logic                   irq_s_q;
    logic                   rise;
    logic                   claim_hit;
    logic                   complete_hit;
    logic                   edge_inc;
    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [EDGE_CNT_W-1:0]  cnt_q;
    logic [EDGE_CNT_W-1:0]  cnt_d;
    logic                   ip_q;
    logic                   busy_q;

    assign irq_s        = sync_q[SYNC_STAGES-1];
    assign rise         = irq_s & ~irq_s_q;
    assign claim_hit    = claim_i & (claim_id_i == ID) & (ID != 4'd0);
    assign complete_hit = complete_i & (complete_id_i == ID) & (ID != 4'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            irq_s_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], irq_i};
            irq_s_q <= irq_s;
        end
    end

    // Edges seen while the source is busy are deferred, saturating at CNT_MAX.
    assign edge_inc = edge_mode_i & rise & (cnt_q != CNT_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (edge_mode_i) begin
                    if (rise) begin
                        state_d = ST_PENDING;
                    end else if (cnt_q != '0) begin
                        state_d = ST_PENDING;
                        cnt_d   = cnt_q - 1'b1;
                    end
                end else if (irq_s) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (edge_inc) cnt_d = cnt_q + 1'b1;
                if (claim_hit) state_d = ST_CLAIMED;
            end
            ST_CLAIMED: begin
                if (edge_inc) cnt_d = cnt_q + 1'b1;
                if (complete_hit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!edge_mode_i) cnt_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ip_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ip_q    <= (state_d == ST_PENDING);
            busy_q  <= (state_d == ST_CLAIMED);
        end
    end

    assign ip_o       = ip_q;
    assign busy_o     = busy_q;
    assign pend_cnt_o = cnt_q;

endmodule

// File: tb/tb_plic_gateway.sv
// Bench for plic_gateway: directed test-plan steps followed by random traffic,
// all checked against a behavioural model of the gateway.
module tb_plic_gateway;

    localparam int         EDGE_CNT_W  = 3;
    localparam int         SYNC_STAGES = 2;
    localparam logic [3:0] MY_ID       = 4'd3;
    localparam int         CNT_MAX     = (1 << EDGE_CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  irq = 1'b0;
    logic                  edge_mode = 1'b0;
    logic                  claim = 1'b0;
    logic [3:0]            claim_id = 4'd0;
    logic                  complete = 1'b0;
    logic [3:0]            complete_id = 4'd0;
    logic                  ip, busy, ip0, busy0;
    logic [EDGE_CNT_W-1:0] pend_cnt, pend_cnt0;

    int errors = 0;
    int checks = 0;

    plic_gateway #(.ID(MY_ID), .EDGE_CNT_W(EDGE_CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_i(clk), .rst_i(rst), .irq_i(irq), .edge_mode_i(edge_mode),
        .claim_i(claim), .claim_id_i(claim_id),
        .complete_i(complete), .complete_id_i(complete_id),
        .ip_o(ip), .busy_o(busy), .pend_cnt_o(pend_cnt)
    );

    plic_gateway #(.ID(4'd0), .EDGE_CNT_W(EDGE_CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut0 (
        .clk_i(clk), .rst_i(rst), .irq_i(irq), .edge_mode_i(edge_mode),
        .claim_i(claim), .claim_id_i(claim_id),
        .complete_i(complete), .complete_id_i(complete_id),
        .ip_o(ip0), .busy_o(busy0), .pend_cnt_o(pend_cnt0)
    );

    always #5 clk = ~clk;

    // Reference model: irq delay line as a queue, gateway as pending/claimed flags.
    bit syncQ[$] = '{0, 0};
    bit mSPrev = 0;
    bit mPend = 0;
    bit mClaim = 0;
    int mCnt = 0;
    bit mRise;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            syncQ  = {};
            repeat (SYNC_STAGES) syncQ.push_back(1'b0);
            mSPrev = 0;
            mPend  = 0;
            mClaim = 0;
            mCnt   = 0;
        end else begin
            mRise = syncQ[0] && !mSPrev;
            if (mClaim) begin
                if (edge_mode && mRise) mCnt = (mCnt < CNT_MAX) ? mCnt + 1 : CNT_MAX;
                if (complete && complete_id == MY_ID) mClaim = 0;
            end else if (mPend) begin
                if (edge_mode && mRise) mCnt = (mCnt < CNT_MAX) ? mCnt + 1 : CNT_MAX;
                if (claim && claim_id == MY_ID) begin
                    mPend  = 0;
                    mClaim = 1;
                end
            end else if (!edge_mode) begin
                mPend = syncQ[0];
            end else if (mRise) begin
                mPend = 1;
            end else if (mCnt > 0) begin
                mPend = 1;
                mCnt  = mCnt - 1;
            end
            if (!edge_mode) mCnt = 0;
            mSPrev = syncQ[0];
            void'(syncQ.pop_front());
            syncQ.push_back(irq);
        end
    end

    task automatic checkValue(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".ip"}, int'(ip), int'(mPend));
        checkValue({tag, ".busy"}, int'(busy), int'(mClaim));
        checkValue({tag, ".cnt"}, int'(pend_cnt), mCnt);
        checkValue({tag, ".busy_id0"}, int'(busy0), 0);
    endtask

    task automatic tick(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput(tag);
        end
    endtask

    task automatic applyStimulus(input logic i, input logic e, input logic c, input logic [3:0] cid,
                                 input logic cp, input logic [3:0] cpid);
        irq = i; edge_mode = e; claim = c; claim_id = cid; complete = cp; complete_id = cpid;
    endtask

    task automatic doClaim(input logic [3:0] id);
        claim = 1'b1; claim_id = id;
        tick(1, "claim");
        claim = 1'b0;
    endtask

    task automatic doComplete(input logic [3:0] id);
        complete = 1'b1; complete_id = id;
        tick(1, "complete");
        complete = 1'b0;
    endtask

    task automatic pulseIrq();
        irq = 1'b1;
        tick(2, "pulse_hi");
        irq = 1'b0;
        tick(2, "pulse_lo");
    endtask

    initial begin
        logic [3:0] idList [4];
        idList = '{4'd3, 4'd5, 4'd3, 4'd0};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset");
        checkValue("reset_ip", int'(ip), 0);
        checkValue("reset_cnt", int'(pend_cnt), 0);
        rst = 1'b0;

        $display("[TB] level mode");
        irq = 1'b1;
        tick(2, "lvl_sync");
        checkValue("lvl_lat_early", int'(ip), 0);
        tick(1, "lvl_lat");
        checkValue("lvl_lat_ip", int'(ip), 1);
        doClaim(MY_ID);
        checkValue("lvl_claim_ip", int'(ip), 0);
        checkValue("lvl_claim_busy", int'(busy), 1);
        doComplete(MY_ID);
        checkValue("lvl_idle_gap_ip", int'(ip), 0);
        checkValue("lvl_idle_gap_busy", int'(busy), 0);
        tick(1, "lvl_repend");
        checkValue("lvl_repend_ip", int'(ip), 1);

        $display("[TB] wrong id / wrong state");
        doClaim(4'd5);
        checkValue("wrong_id_ip", int'(ip), 1);
        checkValue("wrong_id_busy", int'(busy), 0);
        doComplete(MY_ID);
        checkValue("cmpl_in_pend_ip", int'(ip), 1);
        doClaim(4'd0);
        checkValue("id0_ip", int'(ip0), 1);
        checkValue("id0_busy", int'(busy0), 0);

        $display("[TB] level drop");
        doClaim(MY_ID);
        irq = 1'b0;
        tick(3, "drop_wait");
        doComplete(MY_ID);
        tick(3, "drop_idle");
        checkValue("drop_idle_ip", int'(ip), 0);
        irq = 1'b1;
        tick(4, "drop_hi");
        irq = 1'b0;
        tick(4, "drop_lo");
        checkValue("drop_keep_ip", int'(ip), 1);
        doClaim(MY_ID);
        doComplete(MY_ID);
        tick(2, "drop_done");
        checkValue("drop_done_ip", int'(ip), 0);

        $display("[TB] edge deferral");
        edge_mode = 1'b1;
        tick(1, "edge_enter");
        pulseIrq();
        checkValue("edge_first_ip", int'(ip), 1);
        doClaim(MY_ID);
        repeat (9) pulseIrq();
        checkValue("edge_sat_cnt", int'(pend_cnt), 7);
        checkValue("edge_sat_busy", int'(busy), 1);
        doComplete(MY_ID);
        checkValue("edge_cmpl_cnt", int'(pend_cnt), 7);
        for (int k = 0; k < 7; k++) begin
            tick(1, "edge_repend");
            checkValue("edge_repend_ip", int'(ip), 1);
            checkValue("edge_repend_cnt", int'(pend_cnt), 6 - k);
            doClaim(MY_ID);
            doComplete(MY_ID);
        end
        tick(2, "edge_drained");
        checkValue("edge_drained_ip", int'(ip), 0);

        $display("[TB] simultaneous events");
        pulseIrq();
        irq = 1'b1;
        tick(2, "sim_sync");
        claim = 1'b1; claim_id = MY_ID;
        tick(1, "sim_claim_rise");
        claim = 1'b0;
        checkValue("sim_claim_busy", int'(busy), 1);
        checkValue("sim_claim_cnt", int'(pend_cnt), 1);
        irq = 1'b0;
        tick(2, "sim_lo");
        pulseIrq();
        irq = 1'b1;
        tick(1, "sim_hi");
        doComplete(MY_ID);
        checkValue("sim_idle_cnt", int'(pend_cnt), 2);
        tick(1, "sim_idle_rise");
        checkValue("sim_idle_rise_ip", int'(ip), 1);
        checkValue("sim_idle_rise_cnt", int'(pend_cnt), 2);
        irq = 1'b0;
        tick(2, "sim_lo2");

        $display("[TB] async reset");
        doClaim(MY_ID);
        pulseIrq();
        pulseIrq();
        checkValue("rst_pre_cnt", int'(pend_cnt), 4);
        checkValue("rst_pre_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async");
        checkValue("rst_async_busy", int'(busy), 0);
        checkValue("rst_async_cnt", int'(pend_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        tick(5, "rst_after");
        checkValue("rst_after_ip", int'(ip), 0);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 3) == 0) ? ~irq : irq,
                          ($urandom_range(0, 24) == 0) ? ~edge_mode : edge_mode,
                          ($urandom_range(0, 3) == 0), idList[$urandom_range(0, 3)],
                          ($urandom_range(0, 3) == 0), idList[$urandom_range(0, 3)]);
            tick(1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/plic_gateway.md
Name: plic_gateway

Overview:
- Per-source PLIC interrupt gateway. It converts a raw device interrupt line into the pending bit that feeds the per-source priority/ID cell.
- It runs the claim/complete handshake with the target side and blocks re-assertion while a claim is in flight.
- It supports level-triggered sources and edge-triggered sources; edge mode has a saturating count of rising edges that arrive while the source is busy.

Parameters:
- ID, 1, source number this gateway answers to (4-bit, 1..15; 0 reserved, never matches).
- EDGE_CNT_W, 3, width of the deferred-edge counter; max count = 2^EDGE_CNT_W-1.
- SYNC_STAGES, 2, synchroniser depth on irq_i (minimum 2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset: asynchronous, active-high.
- irq_i  in  1  raw device interrupt; asynchronous to clk_i.
- edge_mode_i  in  1  0 = level-triggered, 1 = rising-edge-triggered.
- claim_i  in  1  one-cycle claim strobe from target.
- claim_id_i  in  4  ID being claimed.
- complete_i  in  1  one-cycle completion strobe from target.
- complete_id_i  in  4  ID being completed.
- ip_o  out  1  pending bit to the priority/ID cell.
- busy_o  out  1  claim in flight.
- pend_cnt_o  out  EDGE_CNT_W  deferred-edge count.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; ip_o=0, busy_o=0, pend_cnt_o=0.
  - All synchroniser flops and the edge-detect history flop = 0.
- Synchroniser and edge detect:
  - irq_i passes through SYNC_STAGES flops to give irq_s.
  - rise = irq_s & ~irq_s_q, where irq_s_q is irq_s delayed one cycle.
- Matches:
  - claim_hit = claim_i & (claim_id_i==ID) & (ID!=0).
  - complete_hit = complete_i & (complete_id_i==ID) & (ID!=0).
- State machine, registered: IDLE, PENDING, CLAIMED.
  - IDLE, level mode: irq_s=1 -> PENDING.
  - IDLE, edge mode: rise=1 or pend_cnt>0 -> PENDING.
    - If pend_cnt>0 and rise=0, decrement pend_cnt.
    - If both pend_cnt>0 and rise=1, pend_cnt is unchanged (one consumed, one deferred).
  - PENDING: claim_hit -> CLAIMED. In level mode, a later drop of irq_s does NOT clear pending.
  - CLAIMED: complete_hit -> IDLE. Re-evaluation happens from IDLE on the next cycle, so there is a minimum one IDLE cycle between completion and re-pend.
- Outputs, all registered:
  - ip_o=1 exactly in PENDING.
  - busy_o=1 exactly in CLAIMED.
- Edge counting, edge mode only:
  - rise while in PENDING or CLAIMED -> pend_cnt+1, saturating at 2^EDGE_CNT_W-1; further edges are dropped.
  - A rise that causes IDLE->PENDING is not counted.
- Level mode:
  - pend_cnt is cleared to 0 every cycle edge_mode_i=0.
  - Switching modes does not change state.
- Ignored events:
  - claim_hit outside PENDING, and complete_hit outside CLAIMED.
  - Non-matching IDs.
- Simultaneous events:
  - A rise in the same cycle as claim_hit (PENDING->CLAIMED) increments pend_cnt.
  - A rise in the same cycle as complete_hit increments pend_cnt.
- Latency: irq_i rising, stable, at cycle 0 -> irq_s high after SYNC_STAGES edges -> ip_o high on the next edge (3 clocks for the default).
- Claim: claim_hit in cycle N -> ip_o=0, busy_o=1 in cycle N+1.
- Reset mid-operation: any state returns to IDLE immediately and the pending count is lost.

Test Plan:
- Level, ID=3: irq_i=1 held -> ip_o=1 three clocks later; claim_i with id 3 -> ip_o=0, busy_o=1 next cycle; complete_i with id 3 -> IDLE for one cycle, then ip_o=1 again because irq is still high.
- Level drop: irq_i high for 4 cycles then low, no claim -> ip_o stays 1; claim then complete -> ip_o stays 0.
- Wrong ID and wrong state: claim id 5 while PENDING -> no change; complete id 3 while PENDING -> no change; ID=0 instance never leaves PENDING on claim id 0.
- Edge deferral, EDGE_CNT_W=3: one edge -> PENDING; claim; 9 further edges -> pend_cnt_o=7 (saturated); complete -> re-pends 7 times over successive claim/complete cycles, with pend_cnt_o decrementing 6, 5, ... 0.
- Simultaneous, edge mode: rise coincident with claim_hit -> pend_cnt_o=1 and busy_o=1 the same next cycle; rise with pend_cnt=2 in IDLE -> PENDING, pend_cnt stays 2.
- Async reset asserted mid-CLAIMED with pend_cnt=4 -> ip_o, busy_o, pend_cnt_o = 0 immediately, without waiting for a clock edge; after release, irq_i low -> stays IDLE.
